pipe_stage_hs: RTL and testbench

- Parametrised, handshaked pipeline register. Next generation of the plain EX/MEM stage register; one instance is placed at each stage boundary (IF/ID, ID/EX, EX/ME, ME/WB).
- Carries a control bundle, which is zeroed on bubbles, and a data bundle.
- Supports valid/ready back-pressure with an optional 2-entry skid buffer, synchronous flush, and a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_pkg.sv | 103 ++++++++++
 rtl/pipe_slot.sv | 49 ++++
 rtl/pipe_stage_hs.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_hs.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage registers: bundle widths per
// stage boundary, the EX/ME field layout, and pack/unpack helpers for those bundles.
package pipe_pkg;

    localparam int MAX_CTRL_W = 64;
    localparam logic [MAX_CTRL_W-1:0] NOP_CTRL = '0;

    localparam int IFID_CTRL_W = 1;
    localparam int IFID_DATA_W = 64;
    localparam int IDEX_CTRL_W = 14;
    localparam int IDEX_DATA_W = 143;
    localparam int EXME_CTRL_W = 11;
    localparam int EXME_DATA_W = 138;
    localparam int MEWB_CTRL_W = 3;
    localparam int MEWB_DATA_W = 69;

    // EX/ME control bundle layout, LSB first
    localparam int EXME_CBR_OFF  = 0;
    localparam int EXME_CBR_W    = 2;
    localparam int EXME_NPC_OFF  = 2;
    localparam int EXME_NPC_W    = 2;
    localparam int EXME_MEMW_OFF = 4;
    localparam int EXME_DMT_OFF  = 5;
    localparam int EXME_DMT_W    = 3;
    localparam int EXME_WREG_OFF = 8;
    localparam int EXME_WB_OFF   = 9;
    localparam int EXME_WB_W     = 2;

    // EX/ME data bundle layout, LSB first
    localparam int XLEN          = 32;
    localparam int REG_W         = 5;
    localparam int EXME_RS2_OFF  = 0;
    localparam int EXME_RD_OFF   = 5;
    localparam int EXME_RS2D_OFF = 10;
    localparam int EXME_ALU_OFF  = 42;
    localparam int EXME_RS1I_OFF = 74;
    localparam int EXME_PCI_OFF  = 106;

    typedef struct packed {
        logic [EXME_WB_W-1:0]  wb_sel;
        logic                  write_reg;
        logic [EXME_DMT_W-1:0] dm_type;
        logic                  mem_w;
        logic [EXME_NPC_W-1:0] next_pc_sel;
        logic [EXME_CBR_W-1:0] cond_branch;
    } exme_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc_imm;
        logic [XLEN-1:0]  rs1_imm;
        logic [XLEN-1:0]  alu_out;
        logic [XLEN-1:0]  rs2_data;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs2;
    } exme_data_t;

    function automatic logic [EXME_CTRL_W-1:0] pack_exme_ctrl(input exme_ctrl_t c);
        logic [EXME_CTRL_W-1:0] v;
        v = '0;
        v[EXME_CBR_OFF +: EXME_CBR_W] = c.cond_branch;
        v[EXME_NPC_OFF +: EXME_NPC_W] = c.next_pc_sel;
        v[EXME_MEMW_OFF]              = c.mem_w;
        v[EXME_DMT_OFF +: EXME_DMT_W] = c.dm_type;
        v[EXME_WREG_OFF]              = c.write_reg;
        v[EXME_WB_OFF +: EXME_WB_W]   = c.wb_sel;
        return v;
    endfunction

    function automatic exme_ctrl_t unpack_exme_ctrl(input logic [EXME_CTRL_W-1:0] v);
        exme_ctrl_t c;
        c.cond_branch = v[EXME_CBR_OFF +: EXME_CBR_W];
        c.next_pc_sel = v[EXME_NPC_OFF +: EXME_NPC_W];
        c.mem_w       = v[EXME_MEMW_OFF];
        c.dm_type     = v[EXME_DMT_OFF +: EXME_DMT_W];
        c.write_reg   = v[EXME_WREG_OFF];
        c.wb_sel      = v[EXME_WB_OFF +: EXME_WB_W];
        return c;
    endfunction

    function automatic logic [EXME_DATA_W-1:0] pack_exme_data(input exme_data_t d);
        logic [EXME_DATA_W-1:0] v;
        v = '0;
        v[EXME_RS2_OFF +: REG_W]  = d.rs2;
        v[EXME_RD_OFF +: REG_W]   = d.rd;
        v[EXME_RS2D_OFF +: XLEN]  = d.rs2_data;
        v[EXME_ALU_OFF +: XLEN]   = d.alu_out;
        v[EXME_RS1I_OFF +: XLEN]  = d.rs1_imm;
        v[EXME_PCI_OFF +: XLEN]   = d.pc_imm;
        return v;
    endfunction

    function automatic exme_data_t unpack_exme_data(input logic [EXME_DATA_W-1:0] v);
        exme_data_t d;
        d.rs2      = v[EXME_RS2_OFF +: REG_W];
        d.rd       = v[EXME_RD_OFF +: REG_W];
        d.rs2_data = v[EXME_RS2D_OFF +: XLEN];
        d.alu_out  = v[EXME_ALU_OFF +: XLEN];
        d.rs1_imm  = v[EXME_RS1I_OFF +: XLEN];
        d.pc_imm   = v[EXME_PCI_OFF +: XLEN];
        return d;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus ctrl and data registers with load, kill and hold.
// Kill clears valid and ctrl so a dead entry can never assert downstream enables.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXME_CTRL_W,
    parameter int DATA_W = EXME_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              kill,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Entry register; kill wins over load, data holds on kill for deterministic traces
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            ctrl_r  <= NOP_CTRL[CTRL_W-1:0];
            data_r  <= '0;
        end else if (kill) begin
            valid_r <= 1'b0;
            ctrl_r  <= NOP_CTRL[CTRL_W-1:0];
            data_r  <= data_r;
        end else if (load) begin
            valid_r <= 1'b1;
            ctrl_r  <= ld_ctrl;
            data_r  <= ld_data;
        end else begin
            valid_r <= valid_r;
            ctrl_r  <= ctrl_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign ctrl  = ctrl_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer, synchronous
// flush and a saturating back-pressure cycle counter.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXME_CTRL_W,
    parameter int DATA_W = EXME_DATA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              clr_stats,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              acc_s;
    logic              snd_s;
    logic              m_valid_s;
    logic [CTRL_W-1:0] m_ctrl_s;
    logic [DATA_W-1:0] m_data_s;
    logic              m_load_s;
    logic              m_kill_s;
    logic [CTRL_W-1:0] m_ld_ctrl_s;
    logic [DATA_W-1:0] m_ld_data_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    assign acc_s = in_valid & in_ready;
    assign snd_s = m_valid_s & out_ready;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (m_load_s),
        .kill    (m_kill_s),
        .ld_ctrl (m_ld_ctrl_s),
        .ld_data (m_ld_data_s),
        .valid   (m_valid_s),
        .ctrl    (m_ctrl_s),
        .data    (m_data_s)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic              s_valid_s;
            logic [CTRL_W-1:0] s_ctrl_s;
            logic [DATA_W-1:0] s_data_s;
            logic              s_load_s;
            logic              s_kill_s;

            // Skid control: M refills from S first, S only catches an input M cannot take
            always_comb begin
                m_load_s    = 1'b0;
                m_kill_s    = 1'b0;
                m_ld_ctrl_s = in_ctrl;
                m_ld_data_s = in_data;
                s_load_s    = 1'b0;
                s_kill_s    = 1'b0;
                if (flush) begin
                    m_kill_s = 1'b1;
                    s_kill_s = 1'b1;
                end else if (!m_valid_s || snd_s) begin
                    if (s_valid_s) begin
                        m_load_s    = 1'b1;
                        m_ld_ctrl_s = s_ctrl_s;
                        m_ld_data_s = s_data_s;
                        s_kill_s    = 1'b1;
                    end else if (acc_s) begin
                        m_load_s = 1'b1;
                    end else begin
                        m_kill_s = 1'b1;
                    end
                end else begin
                    s_load_s = acc_s;
                end
            end

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (s_load_s),
                .kill    (s_kill_s),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .valid   (s_valid_s),
                .ctrl    (s_ctrl_s),
                .data    (s_data_s)
            );

            // Ready comes straight from the S valid flop, isolating out_ready from in_ready
            assign in_ready = ~s_valid_s;
        end else begin : g_single
            // Single-entry control: replace on accept, drain on send without accept
            always_comb begin
                m_load_s    = 1'b0;
                m_kill_s    = 1'b0;
                m_ld_ctrl_s = in_ctrl;
                m_ld_data_s = in_data;
                if (flush) begin
                    m_kill_s = 1'b1;
                end else if (acc_s) begin
                    m_load_s = 1'b1;
                end else if (snd_s) begin
                    m_kill_s = 1'b1;
                end else begin
                    m_load_s = 1'b0;
                end
            end

            assign in_ready = ~m_valid_s | out_ready;
        end
    endgenerate

    // Back-pressure cycle counter; clear beats increment, saturates instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= '0;
        end else if (clr_stats) begin
            stall_cnt_r <= '0;
        end else if (m_valid_s && !out_ready && !flush && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign out_valid = m_valid_s;
    assign out_ctrl  = m_valid_s ? m_ctrl_s : NOP_CTRL[CTRL_W-1:0];
    assign out_data  = m_data_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a skid instance (CNT_W=4) and a single-register instance share
// stimulus; both are checked against queue-based models plus directed vector tables.
module tb_pipe_stage_hs;

    localparam int CW = 11;
    localparam int DW = 138;

    typedef logic [CW+DW-1:0] ent_t;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       clr;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic [3:0] cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          clr_stats = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          s_ir, s_ov, c_ir, c_ov;
    logic [CW-1:0] s_oc, c_oc;
    logic [DW-1:0] s_od, c_od;
    logic [3:0]    s_cnt;
    logic [15:0]   c_cnt;

    ent_t          qs[$];
    ent_t          qc[$];
    logic [DW-1:0] mds = '0;
    logic [DW-1:0] mdc = '0;
    int            cnts = 0;
    int            cntc = 0;

    int            checks = 0;
    int            failures = 0;
    vec_t          tab[26];

    always #5 clk = ~clk;

    pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_s (
        .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(s_ir), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_ov), .out_ready(out_ready), .out_ctrl(s_oc), .out_data(s_od),
        .stall_cnt(s_cnt)
    );

    pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_ready(c_ir), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(c_ov), .out_ready(out_ready), .out_ctrl(c_oc), .out_data(c_od),
        .stall_cnt(c_cnt)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic fl, input logic clr);
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_stats = clr;
    endtask

    // Called at posedge+1: move to the negedge and compare both DUTs with the models
    task automatic settle();
        logic ov;
        #4;
        ov = (qs.size() != 0);
        chk("s_out_valid", 160'(s_ov), 160'(ov));
        chk("s_out_ctrl", 160'(s_oc), ov ? 160'(qs[0][CW+DW-1:DW]) : 160'd0);
        chk("s_out_data", 160'(s_od), 160'(mds));
        chk("s_in_ready", 160'(s_ir), 160'(qs.size() < 2));
        chk("s_stall_cnt", 160'(s_cnt), 160'(cnts));
        ov = (qc.size() != 0);
        chk("c_out_valid", 160'(c_ov), 160'(ov));
        chk("c_out_ctrl", 160'(c_oc), ov ? 160'(qc[0][CW+DW-1:DW]) : 160'd0);
        chk("c_out_data", 160'(c_od), 160'(mdc));
        chk("c_in_ready", 160'(c_ir), 160'((qc.size() == 0) || out_ready));
        chk("c_stall_cnt", 160'(c_cnt), 160'(cntc));
    endtask

    // Advance the models by one clock using the currently driven inputs, then step the clock
    task automatic advance();
        logic rdy_s, rdy_c, ov_s, ov_c;
        ov_s  = (qs.size() != 0);
        ov_c  = (qc.size() != 0);
        rdy_s = (qs.size() < 2);
        rdy_c = !ov_c || out_ready;
        if (!rst) begin
            qs.delete(); qc.delete();
            cnts = 0; cntc = 0; mds = '0; mdc = '0;
        end else begin
            if (clr_stats) cnts = 0;
            else if (ov_s && !out_ready && !flush && cnts < 15) cnts++;
            if (clr_stats) cntc = 0;
            else if (ov_c && !out_ready && !flush && cntc < 65535) cntc++;
            if (flush) begin
                qs.delete(); qc.delete();
            end else begin
                if (ov_s && out_ready) void'(qs.pop_front());
                if (in_valid && rdy_s) qs.push_back({in_ctrl, in_data});
                if (ov_c && out_ready) void'(qc.pop_front());
                if (in_valid && rdy_c) qc.push_back({in_ctrl, in_data});
            end
            if (qs.size() != 0) mds = qs[0][DW-1:0];
            if (qc.size() != 0) mdc = qc[0][DW-1:0];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [159:0] r;
        //          iv    d      ordy  fl    clr   ov    od     ir    cnt
        tab[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0};
        tab[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 4'd0};
        tab[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 4'd0};
        tab[3]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 4'd0};
        tab[4]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 4'd0};
        tab[5]  = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 4'd0};
        tab[6]  = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 8'h06, 1'b1, 4'd0};
        tab[7]  = '{1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 4'd0};
        tab[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 4'd0};
        tab[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 4'd0};
        tab[10] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 4'd0};
        tab[11] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 4'd0};
        tab[12] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 4'd1};
        tab[13] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 4'd2};
        tab[14] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 4'd3};
        tab[15] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 4'd3};
        tab[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 4'd3};
        tab[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 4'd3};
        tab[18] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 4'd3};
        tab[19] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 4'd3};
        tab[20] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 4'd4};
        tab[21] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 4'd5};
        tab[22] = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b1, 4'd5};
        tab[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 1'b1, 4'd5};
        tab[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 4'd5};
        tab[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 1'b1, 4'd0};

        // Reset held for two cycles, then one idle cycle after release
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            advance();
        end
        rst = 1'b1;
        settle();
        advance();

        // Directed vectors: streaming, back-pressure, flush, stats clear
        for (int i = 0; i < 26; i++) begin
            drive(tab[i].iv, 11'h5A3, {130'd0, tab[i].d}, tab[i].ordy, tab[i].fl, tab[i].clr);
            settle();
            chk($sformatf("tab%0d_out_valid", i), 160'(s_ov), 160'(tab[i].ov));
            chk($sformatf("tab%0d_out_data", i), 160'(s_od[7:0]), 160'(tab[i].od));
            chk($sformatf("tab%0d_in_ready", i), 160'(s_ir), 160'(tab[i].ir));
            chk($sformatf("tab%0d_stall_cnt", i), 160'(s_cnt), 160'(tab[i].cnt));
            advance();
        end

        // Counter saturation: 20 stall cycles on a 4-bit counter, then clear during a stall
        drive(1'b1, 11'h5A3, {130'd0, 8'h99}, 1'b0, 1'b0, 1'b0);
        settle();
        advance();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            settle();
            advance();
        end
        chk("sat_stall_cnt", 160'(s_cnt), 160'd15);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        settle();
        advance();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("clr_stall_cnt", 160'(s_cnt), 160'd0);

        // Single-register variant: combinational ready and same-cycle replace of M
        drive(1'b1, 11'h0F0, {130'd0, 8'hAB}, 1'b0, 1'b0, 1'b0);
        settle();
        chk("c_ready_low_stalled", 160'(c_ir), 160'd0);
        out_ready = 1'b1;
        #1;
        chk("c_ready_follows_out_ready", 160'(c_ir), 160'd1);
        advance();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("c_replace_data", 160'(c_od[7:0]), 160'h0AB);
        chk("c_replace_ctrl", 160'(c_oc), 160'h0F0);
        advance();

        // Randomised traffic against the queue models
        for (int i = 0; i < 800; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drive($urandom_range(0, 3) != 0, CW'($urandom), r[DW-1:0],
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 49) == 0);
            settle();
            advance();
        end

        // Reset in the middle of traffic: outputs drop at once, without a clock edge
        drive(1'b1, 11'h7FF, {130'd0, 8'hEE}, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            advance();
        end
        rst = 1'b0;
        #1;
        chk("rst_async_s_valid", 160'(s_ov), 160'd0);
        chk("rst_async_s_ctrl", 160'(s_oc), 160'd0);
        chk("rst_async_c_valid", 160'(c_ov), 160'd0);
        qs.delete(); qc.delete();
        cnts = 0; cntc = 0; mds = '0; mdc = '0;
        settle();
        advance();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
